// File: rtl/od_line_receiver.sv
// od_line_receiver
//   Receiver for an open-drain net with a resistive pull-up and slow RC rise.
//   The raw net is synchronised, glitches and slow-edge chatter are rejected by a
//   consecutive-sample filter, and a clean level is published together with edge
//   pulses and a stuck-low alarm.
//
// Optional feature: define RISE_MEASURE_EN to build the release-to-rise timer.
//
// Ports
//   clk          in   1      clock, all state on rising edge
//   rst_n        in   1      synchronous active-low reset
//   line         in   1      raw open-drain net (asynchronous)
//   release_req  in   1      pulse: local driver stopped pulling the net low
//   level        out  1      filtered line level
//   rise         out  1      1-cycle pulse on committed 0->1
//   fall         out  1      1-cycle pulse on committed 1->0
//   stuck_low    out  1      level held low for STUCK_CYCLES cycles
//   rise_valid   out  1      1-cycle pulse, rise_cycles updated
//   rise_cycles  out  CNT_W  cycles from release_req to committed rise
module od_line_receiver #(
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned STUCK_CYCLES  = 1024,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             line,
  input  logic             release_req,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic             stuck_low,
  output logic             rise_valid,
  output logic [CNT_W-1:0] rise_cycles
);

  typedef enum logic [1:0] {
    ST_HIGH,
    ST_PEND_FALL,
    ST_LOW,
    ST_PEND_RISE
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic [CNT_W-1:0] stuck_cnt_q, stuck_cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             low_next;

  // State register, synchroniser and counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= ST_HIGH;
      filt_cnt_q  <= '0;
      stuck_cnt_q <= '0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      sync1_q     <= line;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      filt_cnt_q  <= filt_cnt_d;
      stuck_cnt_q <= stuck_cnt_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    filt_cnt_d  = filt_cnt_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    stuck_cnt_d = '0;
    low_next    = 1'b0;
    unique case (state_q)
      ST_HIGH: begin
        if (!sync2_q) begin
          if (FILTER_CYCLES == 1) begin
            state_d    = ST_LOW;
            filt_cnt_d = '0;
            fall_d     = 1'b1;
          end else begin
            state_d    = ST_PEND_FALL;
            filt_cnt_d = CNT_W'(1);
          end
        end
      end
      ST_PEND_FALL: begin
        if (!sync2_q) begin
          if (filt_cnt_q + CNT_W'(1) == CNT_W'(FILTER_CYCLES)) begin
            state_d    = ST_LOW;
            filt_cnt_d = '0;
            fall_d     = 1'b1;
          end else begin
            filt_cnt_d = filt_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d    = ST_HIGH;
          filt_cnt_d = '0;
        end
      end
      ST_LOW: begin
        if (sync2_q) begin
          if (FILTER_CYCLES == 1) begin
            state_d    = ST_HIGH;
            filt_cnt_d = '0;
            rise_d     = 1'b1;
          end else begin
            state_d    = ST_PEND_RISE;
            filt_cnt_d = CNT_W'(1);
          end
        end
      end
      ST_PEND_RISE: begin
        if (sync2_q) begin
          if (filt_cnt_q + CNT_W'(1) == CNT_W'(FILTER_CYCLES)) begin
            state_d    = ST_HIGH;
            filt_cnt_d = '0;
            rise_d     = 1'b1;
          end else begin
            filt_cnt_d = filt_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d    = ST_LOW;
          filt_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_HIGH;
        filt_cnt_d = '0;
      end
    endcase

    // stuck_cnt holds the number of cycles (including the coming one) spent at
    // level 0; a committed rise moves to HIGH and so clears it in the rise cycle.
    low_next = (state_d == ST_LOW) || (state_d == ST_PEND_RISE);
    if (low_next) begin
      if (stuck_cnt_q == CNT_W'(STUCK_CYCLES)) stuck_cnt_d = stuck_cnt_q;
      else                                     stuck_cnt_d = stuck_cnt_q + CNT_W'(1);
    end
  end

  // Outputs
  always_comb begin
    level     = (state_q == ST_HIGH) || (state_q == ST_PEND_FALL);
    rise      = rise_q;
    fall      = fall_q;
    stuck_low = (stuck_cnt_q == CNT_W'(STUCK_CYCLES));
  end

`ifdef RISE_MEASURE_EN
  logic             armed_q;
  logic [CNT_W-1:0] rise_cnt_q;
  logic [CNT_W-1:0] rise_cycles_q;
  logic             rise_valid_q;

  // A rise being committed this edge takes priority over a coincident
  // release_req, so the report belongs to the earlier arm.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed_q       <= 1'b0;
      rise_cnt_q    <= '0;
      rise_cycles_q <= '0;
      rise_valid_q  <= 1'b0;
    end else begin
      rise_valid_q <= 1'b0;
      if (rise_d && armed_q) begin
        rise_cycles_q <= (rise_cnt_q == '1) ? rise_cnt_q : rise_cnt_q + CNT_W'(1);
        rise_valid_q  <= 1'b1;
        armed_q       <= 1'b0;
      end else if (release_req && !level && !rise_d) begin
        armed_q    <= 1'b1;
        rise_cnt_q <= '0;
      end else if (armed_q && rise_cnt_q != '1) begin
        rise_cnt_q <= rise_cnt_q + CNT_W'(1);
      end
    end
  end

  assign rise_valid  = rise_valid_q;
  assign rise_cycles = rise_cycles_q;
`else
  logic unused_release_req;
  assign unused_release_req = release_req;
  assign rise_valid         = 1'b0;
  assign rise_cycles        = '0;
`endif

endmodule
